vga_scan_out: RTL and testbench

VGA_SCAN_OUT -- requirements
Module: vga_scan_out

---
 rtl/vga_scan_out.sv | 131 +++++++++++++
 tb/tb_vga_scan_out.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// VGA raster generator: walks the screen, requests pixel coordinates ahead of display,
// and delays the sync/blank timing so it lines up with the returned grayscale sample.
`timescale 1ns/1ps
module vga_scan_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 2,
    parameter int DATA_W   = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              pixel_en,
    input  logic [DATA_W-1:0] pixel_in,
    output logic [9:0]        next_x,
    output logic [9:0]        next_y,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic [DATA_W-1:0] vga_r,
    output logic [DATA_W-1:0] vga_g,
    output logic [DATA_W-1:0] vga_b,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]          h_cnt_q, h_cnt_d;
    logic [9:0]          v_cnt_q, v_cnt_d;
    logic [9:0]          next_x_q, next_x_d;
    logic [9:0]          next_y_q, next_y_d;
    logic                first_q, first_d;
    logic                frame_start_q, frame_start_d;
    logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_LAT-1:0] act_pipe_q, act_pipe_d;
    logic [DATA_W-1:0]   rgb_q, rgb_d;
    logic                hs_raw, vs_raw, act_raw;

    assign hs_raw  = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    assign vs_raw  = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    assign act_raw = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        next_x_d      = next_x_q;
        next_y_d      = next_y_q;
        first_d       = first_q;
        frame_start_d = frame_start_q;
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        act_pipe_d    = act_pipe_q;
        rgb_d         = rgb_q;
        if (pixel_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            next_x_d = (h_cnt_d < H_ACT) ? h_cnt_d : 10'd0;
            next_y_d = (v_cnt_d < V_ACT) ? v_cnt_d : 10'd0;
            // Reset leaves (0,0) already requested, so the first tick flags that frame.
            frame_start_d = first_q || ((h_cnt_d == 10'd0) && (v_cnt_d == 10'd0));
            first_d       = 1'b0;
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                hs_pipe_d[i]  = hs_pipe_q[i-1];
                vs_pipe_d[i]  = vs_pipe_q[i-1];
                act_pipe_d[i] = act_pipe_q[i-1];
            end
            hs_pipe_d[0]  = hs_raw;
            vs_pipe_d[0]  = vs_raw;
            act_pipe_d[0] = act_raw;
            rgb_d = act_pipe_q[PIPE_LAT-1] ? pixel_in : '0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            next_x_q      <= 10'd0;
            next_y_q      <= 10'd0;
            first_q       <= 1'b1;
            frame_start_q <= 1'b0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            act_pipe_q    <= '0;
            rgb_q         <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            next_x_q      <= next_x_d;
            next_y_q      <= next_y_d;
            first_q       <= first_d;
            frame_start_q <= frame_start_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
            act_pipe_q    <= act_pipe_d;
            rgb_q         <= rgb_d;
        end
    end

    // Grayscale display: one register drives all three channels.
    assign next_x      = next_x_q;
    assign next_y      = next_y_q;
    assign hsync       = hs_pipe_q[PIPE_LAT-1];
    assign vsync       = vs_pipe_q[PIPE_LAT-1];
    assign blank_n     = act_pipe_q[PIPE_LAT-1];
    assign vga_r       = rgb_q;
    assign vga_g       = rgb_q;
    assign vga_b       = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out on a shrunken 15x8 raster, with PIPE_LAT=2 and PIPE_LAT=4 copies.
`timescale 1ns/1ps
module tb_vga_scan_out;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 15
    localparam int VT = VA + VF + VS + VB;   // 8
    localparam int FT = HT * VT;             // 120

    logic       clk = 1'b0;
    logic       reset;
    logic       pixel_en;
    logic [7:0] pin2, pin4;
    logic [9:0] nx2, ny2, nx4, ny4;
    logic       hs2, vs2, bn2, fs2, hs4, vs4, bn4, fs4;
    logic [7:0] r2, g2, b2, r4, g4, b4;

    logic [9:0] hist2 [0:4];
    logic [9:0] hist4 [0:4];
    int n;
    int passed = 0;
    int total  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    vga_scan_out #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .PIPE_LAT(2), .DATA_W(8)) u_dut2 (
        .clk_in(clk), .reset(reset), .pixel_en(pixel_en), .pixel_in(pin2),
        .next_x(nx2), .next_y(ny2), .hsync(hs2), .vsync(vs2), .blank_n(bn2),
        .vga_r(r2), .vga_g(g2), .vga_b(b2), .frame_start(fs2));

    vga_scan_out #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                   .PIPE_LAT(4), .DATA_W(8)) u_dut4 (
        .clk_in(clk), .reset(reset), .pixel_en(pixel_en), .pixel_in(pin4),
        .next_x(nx4), .next_y(ny4), .hsync(hs4), .vsync(vs4), .blank_n(bn4),
        .vga_r(r4), .vga_g(g4), .vga_b(b4), .frame_start(fs4));

    // Reference model in closed form of the tick count since reset.
    function automatic logic [7:0] f(int x);
        return 8'((x * 37 + 11) & 255);
    endfunction
    function automatic int hpos(int m); return m % HT; endfunction
    function automatic int vpos(int m); return (m / HT) % VT; endfunction
    function automatic bit act(int m); return (hpos(m) < HA) && (vpos(m) < VA); endfunction
    function automatic int exp_nx(int m); return (hpos(m) < HA) ? hpos(m) : 0; endfunction
    function automatic int exp_ny(int m); return (vpos(m) < VA) ? vpos(m) : 0; endfunction
    function automatic int exp_hs(int m, int l);
        if (m < l) return 1;
        return (hpos(m - l) >= HA + HF && hpos(m - l) <= HA + HF + HS - 1) ? 0 : 1;
    endfunction
    function automatic int exp_vs(int m, int l);
        if (m < l) return 1;
        return (vpos(m - l) >= VA + VF && vpos(m - l) <= VA + VF + VS - 1) ? 0 : 1;
    endfunction
    function automatic int exp_bn(int m, int l);
        return (m >= l && act(m - l)) ? 1 : 0;
    endfunction
    function automatic int exp_fs(int m);
        return (m == 1 || (m > 0 && m % FT == 0)) ? 1 : 0;
    endfunction
    function automatic int exp_rgb(int m, int l);
        if (m >= 1 && m - 1 >= l && act(m - 1 - l)) return int'(f(hpos(m - 1 - l)));
        return 0;
    endfunction

    task automatic chk(string tag, int obs, int expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_one(int l, int nx, int ny, int hs, int vs, int bn, int fs,
                             int r, int g, int b);
        string s;
        s = $sformatf("L%0d n%0d", l, n);
        chk({s, " next_x"},  nx, exp_nx(n));
        chk({s, " next_y"},  ny, exp_ny(n));
        chk({s, " hsync"},   hs, exp_hs(n, l));
        chk({s, " vsync"},   vs, exp_vs(n, l));
        chk({s, " blank_n"}, bn, exp_bn(n, l));
        chk({s, " frame_start"}, fs, exp_fs(n));
        chk({s, " vga_r"},   r, exp_rgb(n, l));
        chk({s, " vga_g"},   g, exp_rgb(n, l));
        chk({s, " vga_b"},   b, exp_rgb(n, l));
    endtask

    task automatic check_both();
        check_one(2, int'(nx2), int'(ny2), int'(hs2), int'(vs2), int'(bn2), int'(fs2),
                  int'(r2), int'(g2), int'(b2));
        check_one(4, int'(nx4), int'(ny4), int'(hs4), int'(vs4), int'(bn4), int'(fs4),
                  int'(r4), int'(g4), int'(b4));
    endtask

    task automatic reset_model();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            hist2[i] = 10'd0;
            hist4[i] = 10'd0;
        end
        pin2 = f(0);
        pin4 = f(0);
    endtask

    // One pixel_en pulse; the memory path model returns f(next_x) PIPE_LAT ticks later.
    task automatic tick();
        @(negedge clk) pixel_en = 1'b1;
        @(negedge clk) pixel_en = 1'b0;
        n++;
        for (int i = 4; i > 0; i--) begin
            hist2[i] = hist2[i-1];
            hist4[i] = hist4[i-1];
        end
        hist2[0] = nx2;
        hist4[0] = nx4;
        pin2 = f(int'(hist2[2]));
        pin4 = f(int'(hist4[4]));
    endtask

    int hs_fall[$];
    int vs_fall[$];
    int hs_low_cnt, vs_low_cnt, bn_high_cnt;
    logic prev_hs, prev_vs;

    initial begin
        reset    = 1'b1;
        pixel_en = 1'b0;
        reset_model();
        #12;
        check_both();
        @(negedge clk) reset = 1'b0;
        check_both();

        hs_low_cnt  = 0;
        vs_low_cnt  = 0;
        bn_high_cnt = 0;
        prev_hs     = hs2;
        prev_vs     = vs2;
        for (int k = 0; k < 250; k++) begin
            tick();
            check_both();
            if (prev_hs && !hs2) hs_fall.push_back(n);
            if (prev_vs && !vs2) vs_fall.push_back(n);
            prev_hs = hs2;
            prev_vs = vs2;
            if (n >= 121 && n <= 240) begin
                hs_low_cnt  += hs2 ? 0 : 1;
                vs_low_cnt  += vs2 ? 0 : 1;
                bn_high_cnt += bn2 ? 1 : 0;
            end
            if (n == 3)  chk("col0 rgb L2", int'(r2), 11);
            if (n == 4)  chk("col1 rgb L2", int'(r2), 48);
            if (n == 10) chk("col7 rgb L2", int'(r2), 14);
            if (n == 11) chk("col8 blanked rgb L2", int'(r2), 0);
            if (n == 5)  chk("col0 rgb L4", int'(r4), 11);
            if (n == 13) chk("hsync before fall L4", int'(hs4), 1);
            if (n == 14) chk("hsync fall L4", int'(hs4), 0);
            if (n == 240) begin
                chk("wrap frame_start", int'(fs2), 1);
                chk("wrap next_x", int'(nx2), 0);
                chk("wrap next_y", int'(ny2), 0);
            end
            if (n == 241) chk("frame_start one tick", int'(fs2), 0);
        end
        chk("hsync low per frame", hs_low_cnt, 24);
        chk("vsync low per frame", vs_low_cnt, 30);
        chk("blank_n high per frame", bn_high_cnt, 32);
        chk("hsync fall count", hs_fall.size() >= 2 ? 1 : 0, 1);
        if (hs_fall.size() >= 2) begin
            chk("hsync first fall", hs_fall[0], 12);
            chk("hsync period", hs_fall[1] - hs_fall[0], 15);
        end
        chk("vsync fall count", vs_fall.size() >= 2 ? 1 : 0, 1);
        if (vs_fall.size() >= 2) begin
            chk("vsync first fall", vs_fall[0], 77);
            chk("vsync period", vs_fall[1] - vs_fall[0], 120);
        end

        // Outputs must freeze while pixel_en stays low.
        repeat (50) @(negedge clk);
        check_both();

        for (int k = 0; k < 200 && !(hpos(n) == 5 && vpos(n) == 2); k++) begin
            tick();
            check_both();
        end
        chk("mid position x", int'(nx2), 5);
        chk("mid position y", int'(ny2), 2);

        // Reset between clock edges must clear outputs before the next rising edge.
        @(negedge clk);
        #3 reset = 1'b1;
        reset_model();
        #1;
        check_both();
        @(negedge clk) reset = 1'b0;
        check_both();
        for (int k = 0; k < 20; k++) begin
            tick();
            check_both();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
